// File: rtl/out_pkg.sv
// -----------------------------------------------------------------------------
// out_pkg
// Shared definitions for the out_buf output FIFO slice: default geometry and
// the occupancy-counter width helper.
// -----------------------------------------------------------------------------
package out_pkg;

    localparam int OUT_WIDTH_DEF = 8;
    localparam int OUT_DEPTH_DEF = 4;

    // Occupancy must represent 0..depth inclusive, hence one bit more than
    // the pointer width.
    function automatic int out_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : out_pkg

// File: rtl/out_buf_mem.sv
// -----------------------------------------------------------------------------
// out_buf_mem
// DEPTH x WIDTH register array backing the out_buf FIFO.
//
// Ports:
//   CLK    in   clock, writes on the falling edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  asynchronous read data (mem[raddr])
// -----------------------------------------------------------------------------
module out_buf_mem
    import out_pkg::*;
#(
    parameter  int WIDTH = OUT_WIDTH_DEF,
    parameter  int DEPTH = OUT_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and leaving it unreset lets it map onto plain registers
    // or RAM without a reset fan-out to every bit.
    always_ff @(negedge CLK) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples pre-edge values regardless of block ordering.
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : out_buf_mem

// File: rtl/out_buf.sv
// -----------------------------------------------------------------------------
// out_buf
// DEPTH-entry output FIFO that captures DBUS writes on the active-low load
// strobe and drains them to a slower consumer via a valid/ready handshake.
// OBUS holds the last value the consumer accepted, so a static display can
// hang off OBUS exactly as it did off the old single-byte output register.
// All state updates on the falling CLK edge, like the other bus registers.
//
// Ports:
//   CLK      in   clock (falling-edge active)
//   nCLR     in   asynchronous active-low reset
//   nLo      in   active-low load strobe; pushes DBUS
//   DBUS     in   data bus
//   ODATA    out  FIFO head, valid while OVALID=1
//   OVALID   out  FIFO non-empty
//   ORDY     in   consumer ready; transfer when OVALID & ORDY at the edge
//   OBUS     out  last transferred value (registered)
//   FULL     out  COUNT == DEPTH
//   EMPTY    out  COUNT == 0
//   COUNT    out  occupancy 0..DEPTH
//   OVF      out  sticky overflow flag
//   nOVFclr  in   active-low synchronous clear of OVF
// -----------------------------------------------------------------------------
module out_buf
    import out_pkg::*;
#(
    parameter  int WIDTH = OUT_WIDTH_DEF,
    parameter  int DEPTH = OUT_DEPTH_DEF,
    localparam int CW    = out_cw(DEPTH)
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             nLo,
    input  logic [WIDTH-1:0] DBUS,
    output logic [WIDTH-1:0] ODATA,
    output logic             OVALID,
    input  logic             ORDY,
    output logic [WIDTH-1:0] OBUS,
    output logic             FULL,
    output logic             EMPTY,
    output logic [CW-1:0]    COUNT,
    output logic             OVF,
    input  logic             nOVFclr
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] obus_q;
    logic             ovf_q;
    logic [WIDTH-1:0] head;

    logic load_req;
    logic pop;
    logic push;
    logic ovf_set;

    // Flags come from the registered count only; pointers are free to wrap
    // and equal pointers alone cannot tell full from empty.
    assign EMPTY  = (count == '0);
    assign FULL   = (count == CNT_FULL);
    assign OVALID = ~EMPTY;
    assign ODATA  = head;
    assign COUNT  = count;
    assign OBUS   = obus_q;
    assign OVF    = ovf_q;

    // Pop sees only registered occupancy, so a value written on this edge is
    // never forwarded straight to OBUS.
    assign load_req = ~nLo;
    assign pop      = OVALID & ORDY;
    assign push     = load_req & (~FULL | pop);
    assign ovf_set  = load_req & FULL & ~pop;

    out_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .we    (push),
        .waddr (wptr),
        .wdata (DBUS),
        .raddr (rptr),
        .rdata (head)
    );

    always_ff @(negedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            obus_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural AW-bit overflow is mod DEPTH.
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr   <= rptr + 1'b1;
                obus_q <= head;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A dropped write on the same edge as a clear keeps the flag set.
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (!nOVFclr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule : out_buf

// File: tb/tb_out_buf.sv
// -----------------------------------------------------------------------------
// tb_out_buf
// Self-checking bench for out_buf (WIDTH=8, DEPTH=4).
// -----------------------------------------------------------------------------
module tb_out_buf;
    import out_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = out_cw(DEPTH);

    logic             CLK;
    logic             nCLR;
    logic             nLo;
    logic [WIDTH-1:0] DBUS;
    logic [WIDTH-1:0] ODATA;
    logic             OVALID;
    logic             ORDY;
    logic [WIDTH-1:0] OBUS;
    logic             FULL;
    logic             EMPTY;
    logic [CW-1:0]    COUNT;
    logic             OVF;
    logic             nOVFclr;

    int n_checks = 0;
    int n_errors = 0;

    out_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .nCLR    (nCLR),
        .nLo     (nLo),
        .DBUS    (DBUS),
        .ODATA   (ODATA),
        .OVALID  (OVALID),
        .ORDY    (ORDY),
        .OBUS    (OBUS),
        .FULL    (FULL),
        .EMPTY   (EMPTY),
        .COUNT   (COUNT),
        .OVF     (OVF),
        .nOVFclr (nOVFclr)
    );

    // Falling edges at 5, 15, 25 ...; outputs sampled just after rising edges.
    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    // ---------------- reference model: a plain queue ----------------
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] m_obus;
    logic             m_ovf;

    task automatic model_reset();
        mq.delete();
        m_obus = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_step(input logic nlo, input logic [WIDTH-1:0] d,
                              input logic rdy, input logic nclr_ovf);
        bit do_pop, do_push;
        do_pop  = (mq.size() > 0) && rdy;
        do_push = !nlo && ((mq.size() < DEPTH) || do_pop);
        if (do_pop) m_obus = mq.pop_front();
        if (do_push) mq.push_back(d);
        if (!nlo && !do_push) m_ovf = 1'b1;
        else if (!nclr_ovf) m_ovf = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"},  32'(COUNT), 32'(mq.size()));
        check({tag, ".empty"},  32'(EMPTY), 32'(mq.size() == 0));
        check({tag, ".full"},   32'(FULL),  32'(mq.size() == DEPTH));
        check({tag, ".ovalid"}, 32'(OVALID), 32'(mq.size() != 0));
        check({tag, ".obus"},   32'(OBUS),  32'(m_obus));
        check({tag, ".ovf"},    32'(OVF),   32'(m_ovf));
        if (mq.size() != 0) check({tag, ".odata"}, 32'(ODATA), 32'(mq[0]));
    endtask

    // One falling (active) edge, then settle to just past the rising edge.
    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input logic nlo, input logic [WIDTH-1:0] d,
                         input logic rdy, input logic nclr_ovf);
        nLo = nlo; DBUS = d; ORDY = rdy; nOVFclr = nclr_ovf;
        model_step(nlo, d, rdy, nclr_ovf);
        tick();
    endtask

    task automatic idle_inputs();
        nLo = 1'b1; DBUS = '0; ORDY = 1'b0; nOVFclr = 1'b1;
    endtask

    // Mid-cycle async reset: outputs must clear before any clock edge.
    task automatic pulse_reset(input string tag);
        #1 nCLR = 1'b0;
        #1;
        model_reset();
        check_model({tag, ".in_reset"});
        #1 nCLR = 1'b1;
    endtask

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic             nlo;
        logic [WIDTH-1:0] dbus;
        logic             ordy;
        logic             novfclr;
        int               exp_count;
        logic [WIDTH-1:0] exp_obus;
        logic             exp_ovf;
        logic [WIDTH-1:0] exp_head;   // checked only when exp_count != 0
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic nlo, input logic [WIDTH-1:0] d, input logic rdy,
                                input logic nclr, input int c, input logic [WIDTH-1:0] ob,
                                input logic ov, input logic [WIDTH-1:0] hd);
        vec_t v;
        v.nlo = nlo; v.dbus = d; v.ordy = rdy; v.novfclr = nclr;
        v.exp_count = c; v.exp_obus = ob; v.exp_ovf = ov; v.exp_head = hd;
        return v;
    endfunction

    initial begin
        idle_inputs();
        nCLR = 1'b0;
        model_reset();
        repeat (2) tick();
        nCLR = 1'b1;

        // --- 1: mid-cycle reset, then idle edges leave everything alone ---
        tick();
        pulse_reset("reset");
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 8'hFF, 1'b0, 1'b1);
            check_model($sformatf("idle%0d", i));
        end

        // --- 2..4 and corner rows: fixed vectors with hand-derived results ---
        //            nLo   DBUS   ORDY  nOVF  COUNT OBUS   OVF   head
        vecs.push_back(mk(0, 8'hA5, 0, 1, 1, 8'h00, 0, 8'hA5)); // basic push
        vecs.push_back(mk(1, 8'h00, 1, 1, 0, 8'hA5, 0, 8'h00)); // basic pop
        vecs.push_back(mk(0, 8'h11, 0, 1, 1, 8'hA5, 0, 8'h11));
        vecs.push_back(mk(0, 8'h22, 0, 1, 2, 8'hA5, 0, 8'h11));
        vecs.push_back(mk(0, 8'h33, 0, 1, 3, 8'hA5, 0, 8'h11));
        vecs.push_back(mk(0, 8'h44, 0, 1, 4, 8'hA5, 0, 8'h11)); // full
        vecs.push_back(mk(0, 8'h55, 0, 1, 4, 8'hA5, 1, 8'h11)); // dropped, OVF
        vecs.push_back(mk(1, 8'h00, 1, 1, 3, 8'h11, 1, 8'h22));
        vecs.push_back(mk(1, 8'h00, 1, 1, 2, 8'h22, 1, 8'h33));
        vecs.push_back(mk(1, 8'h00, 1, 1, 1, 8'h33, 1, 8'h44));
        vecs.push_back(mk(1, 8'h00, 1, 1, 0, 8'h44, 1, 8'h00)); // 0x55 never seen
        vecs.push_back(mk(1, 8'h00, 1, 0, 0, 8'h44, 0, 8'h00)); // ORDY while empty, clear OVF
        vecs.push_back(mk(0, 8'h11, 0, 1, 1, 8'h44, 0, 8'h11));
        vecs.push_back(mk(0, 8'h22, 0, 1, 2, 8'h44, 0, 8'h11));
        vecs.push_back(mk(0, 8'h33, 0, 1, 3, 8'h44, 0, 8'h11));
        vecs.push_back(mk(0, 8'h44, 0, 1, 4, 8'h44, 0, 8'h11));
        vecs.push_back(mk(0, 8'h66, 1, 1, 4, 8'h11, 0, 8'h22)); // full push+pop
        vecs.push_back(mk(1, 8'h00, 1, 1, 3, 8'h22, 0, 8'h33));
        vecs.push_back(mk(1, 8'h00, 1, 1, 2, 8'h33, 0, 8'h44));
        vecs.push_back(mk(1, 8'h00, 1, 1, 1, 8'h44, 0, 8'h66));
        vecs.push_back(mk(1, 8'h00, 1, 1, 0, 8'h66, 0, 8'h00)); // 0x66 fifth
        vecs.push_back(mk(0, 8'h77, 1, 1, 1, 8'h66, 0, 8'h77)); // no bypass
        vecs.push_back(mk(1, 8'h00, 1, 1, 0, 8'h77, 0, 8'h00));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].nlo, vecs[i].dbus, vecs[i].ordy, vecs[i].novfclr);
            check($sformatf("vec%0d.count", i), 32'(COUNT), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d.empty", i), 32'(EMPTY), 32'(vecs[i].exp_count == 0));
            check($sformatf("vec%0d.full", i),  32'(FULL),  32'(vecs[i].exp_count == DEPTH));
            check($sformatf("vec%0d.ovalid", i), 32'(OVALID), 32'(vecs[i].exp_count != 0));
            check($sformatf("vec%0d.obus", i),  32'(OBUS),  32'(vecs[i].exp_obus));
            check($sformatf("vec%0d.ovf", i),   32'(OVF),   32'(vecs[i].exp_ovf));
            if (vecs[i].exp_count != 0)
                check($sformatf("vec%0d.odata", i), 32'(ODATA), 32'(vecs[i].exp_head));
        end
        idle_inputs();

        // --- 5: wrap-around, 3 rounds of push 3 / pop 3 ---
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
                apply(1'b0, 8'(3 * r + k + 1), 1'b0, 1'b1);
                check_model($sformatf("wrap%0d.push%0d", r, k));
            end
            for (int k = 0; k < 3; k++) begin
                apply(1'b1, 8'h00, 1'b1, 1'b1);
                check($sformatf("wrap%0d.obus%0d", r, k), 32'(OBUS), 32'(3 * r + k + 1));
            end
            check($sformatf("wrap%0d.count", r), 32'(COUNT), 32'd0);
        end

        // --- 6a: reset with COUNT=2 and OVF=1 ---
        for (int k = 0; k < 5; k++) apply(1'b0, 8'(8'hB0 + k), 1'b0, 1'b1);
        repeat (2) apply(1'b1, 8'h00, 1'b1, 1'b1);
        check_model("pre_reset");
        check("pre_reset.count2", 32'(COUNT), 32'd2);
        check("pre_reset.ovf1", 32'(OVF), 32'd1);
        idle_inputs();
        pulse_reset("midop");
        apply(1'b1, 8'h00, 1'b1, 1'b1);
        check_model("post_reset");

        // --- 6b: overflow and clear on the same edge: set wins ---
        for (int k = 0; k < 4; k++) apply(1'b0, 8'(8'hC0 + k), 1'b0, 1'b1);
        apply(1'b0, 8'hCF, 1'b0, 1'b0);
        check("ovf_prec.ovf", 32'(OVF), 32'd1);
        check_model("ovf_prec");
        apply(1'b1, 8'h00, 1'b0, 1'b0);
        check("ovf_clear.ovf", 32'(OVF), 32'd0);

        // --- randomized traffic against the queue model ---
        for (int i = 0; i < 400; i++) begin
            int rdy_pct;
            rdy_pct = (i / 50) % 2 ? 20 : 70;   // alternate drain-heavy and fill-heavy phases
            apply(1'($urandom_range(1)), 8'($urandom),
                  1'($urandom_range(99) < rdy_pct), 1'($urandom_range(9) != 0));
            check_model($sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_out_buf
